// File: rtl/line_fill_scheduler_if.sv
// Scanline fill bus: VGA end-of-line input, renderer request/pixel handshakes,
// line-buffer write port and display status.
interface line_fill_scheduler_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_BITS  = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  i_lineend;
  logic                  o_req_valid;
  logic [LINE_BITS-1:0]  o_req_line;
  logic                  i_req_ready;
  logic                  i_pix_valid;
  logic [DATA_WIDTH-1:0] i_pix_data;
  logic                  o_pix_ready;
  logic                  o_wr_en;
  logic [ADDR_WIDTH:0]   o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  o_rd_bank;
  logic [LINE_BITS-1:0]  o_disp_line;
  logic                  o_underrun;
  logic                  o_busy;

  modport master (
    input  i_lineend, i_req_ready, i_pix_valid, i_pix_data,
    output o_req_valid, o_req_line, o_pix_ready, o_wr_en, o_wr_addr,
           o_wr_data, o_rd_bank, o_disp_line, o_underrun, o_busy
  );

  modport slave (
    output i_lineend, i_req_ready, i_pix_valid, i_pix_data,
    input  o_req_valid, o_req_line, o_pix_ready, o_wr_en, o_wr_addr,
           o_wr_data, o_rd_bank, o_disp_line, o_underrun, o_busy
  );
endinterface

// File: rtl/line_fill_scheduler.sv
// Ping-pong scanline fill sequencer: requests the next line from the renderer,
// streams its pixels into the bank the display is not reading, and swaps banks
// on each end-of-line blanking edge (flagging an underrun if the line is late).
module line_fill_scheduler #(
  parameter int LINE_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_LINES  = 768,
  parameter int LINE_BITS  = 12,
  parameter int DATA_WIDTH = 12
) (
  input logic CLK,
  input logic RST,
  line_fill_scheduler_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [LINE_BITS-1:0]  LAST_LINE = LINE_BITS'(NUM_LINES - 1);

  state_t                state, state_nxt;
  logic                  lineend_q;
  logic                  rd_bank, wr_bank;
  logic [LINE_BITS-1:0]  disp_line, disp_nxt;
  logic [LINE_BITS-1:0]  req_line;
  logic [ADDR_WIDTH-1:0] pix_cnt, pix_cnt_nxt;
  logic                  underrun, underrun_nxt;
  logic                  swap;
  logic                  le_edge;
  logic                  pix_ready;
  logic                  accept;
  logic                  last_pix;
  logic [DATA_WIDTH-1:0] wr_data;

  // Line numbers wrap at the frame height, which is not a power of two.
  function automatic logic [LINE_BITS-1:0] line_inc(input logic [LINE_BITS-1:0] l);
    if (l == LAST_LINE) return '0;
    return l + LINE_BITS'(1);
  endfunction

  assign le_edge   = bus.i_lineend & ~lineend_q;
  assign pix_ready = (state == S_FILL) & ~RST;
  assign accept    = pix_ready & bus.i_pix_valid;
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign wr_data   = bus.i_pix_data;

  assign bus.o_req_valid = (state == S_REQ) & ~RST;
  assign bus.o_req_line  = req_line;
  assign bus.o_pix_ready = pix_ready;
  assign bus.o_wr_en     = accept;
  assign bus.o_wr_addr   = {wr_bank, pix_cnt};
  assign bus.o_wr_data   = wr_data;
  assign bus.o_rd_bank   = rd_bank;
  assign bus.o_disp_line = disp_line;
  assign bus.o_underrun  = underrun;
  assign bus.o_busy      = (state == S_REQ) | (state == S_FILL);

  // Next state, pixel counter, bank swap and underrun decision.
  always_comb begin
    state_nxt    = state;
    pix_cnt_nxt  = pix_cnt;
    swap         = 1'b0;
    underrun_nxt = 1'b0;
    disp_nxt     = le_edge ? line_inc(disp_line) : disp_line;
    case (state)
      S_REQ: begin
        if (bus.i_req_ready) begin
          state_nxt   = S_FILL;
          pix_cnt_nxt = '0;
        end
        if (le_edge) underrun_nxt = 1'b1;
      end
      S_FILL: begin
        if (accept) begin
          if (last_pix) begin
            pix_cnt_nxt = '0;
            // Finishing the line on the blanking edge itself is still on time.
            if (le_edge) begin
              swap      = 1'b1;
              state_nxt = S_REQ;
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            pix_cnt_nxt = pix_cnt + ADDR_WIDTH'(1);
          end
        end
        if (le_edge && !(accept && last_pix)) underrun_nxt = 1'b1;
      end
      S_DONE: begin
        if (le_edge) begin
          swap      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // State and bookkeeping registers; reset primes a request for line 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_REQ;
      lineend_q <= 1'b0;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b1;
      disp_line <= LAST_LINE;
      req_line  <= '0;
      pix_cnt   <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      lineend_q <= bus.i_lineend;
      disp_line <= disp_nxt;
      pix_cnt   <= pix_cnt_nxt;
      underrun  <= underrun_nxt;
      if (swap) begin
        rd_bank  <= ~rd_bank;
        wr_bank  <= ~wr_bank;
        req_line <= line_inc(disp_nxt);
      end
    end
  end

endmodule
